// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD (double-dabble) controller.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef logic [3:0] digit_t;

    localparam digit_t ADJ_THRESH = 4'd4;
    localparam digit_t ADJ_ADD    = 4'd3;

    // Pre-shift correction so a digit >= 5 carries into the next digit after doubling.
    function automatic digit_t digit_adj(input digit_t d);
        return (d > ADJ_THRESH) ? digit_t'(d + ADJ_ADD) : d;
    endfunction

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

endpackage

// File: rtl/bcd_seq_ctrl_if.sv
// Input and result valid/ready handshakes of the BCD controller.
interface bcd_seq_ctrl_if #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic                  neg;

    modport master (output in_valid, bin, out_ready,
                    input  in_ready, out_valid, bcd, neg);
    modport slave  (input  in_valid, bin, out_ready,
                    output in_ready, out_valid, bcd, neg);
endinterface

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble iteration: adjust digits, then shift {digits, shreg} left by one.
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic [4*DIGITS-1:0] digits_i,
    input  logic [BIN_W-1:0]    shreg_i,
    output logic [4*DIGITS-1:0] digits_o,
    output logic [BIN_W-1:0]    shreg_o
);
    logic [4*DIGITS-1:0] adj;

    always_comb begin
        adj = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            adj[4*k +: 4] = digit_adj(digits_i[4*k +: 4]);
        end
        digits_o = {adj[4*DIGITS-2:0], shreg_i[BIN_W-1]};
        shreg_o  = {shreg_i[BIN_W-2:0], 1'b0};
    end
endmodule

// File: rtl/bcd_seq_ctrl.sv
// Sequential binary-to-BCD controller, one dabble iteration per clock.
// Optional build macro BCD_SEQ_SIGNED_EN: treat bin as two's complement and report the sign on neg.
module bcd_seq_ctrl
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_seq_ctrl_if.slave        bus,
    output logic                 busy
);
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned BCD_W = 4 * DIGITS;

    if (pow10(DIGITS) <= ((64'd1 << BIN_W) - 64'd1)) begin : g_bad_cfg
        $error("bcd_seq_ctrl: DIGITS too small to represent 2**BIN_W-1");
    end

    state_e             state_q, state_d;
    logic [BCD_W-1:0]   digits_q, digits_d;
    logic [BIN_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [BCD_W-1:0]   step_digits;
    logic [BIN_W-1:0]   step_shreg;
    logic [BIN_W-1:0]   load_val;

    bcd_dabble_step #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_step (
        .digits_i (digits_q),
        .shreg_i  (shreg_q),
        .digits_o (step_digits),
        .shreg_o  (step_shreg)
    );

`ifdef BCD_SEQ_SIGNED_EN
    logic sign_q, sign_d;
    logic neg_q, neg_d;
    // Negation of the most negative value wraps to itself, which is the correct unsigned magnitude.
    assign load_val = bus.bin[BIN_W-1] ? BIN_W'(-bus.bin) : bus.bin;
    assign bus.neg  = neg_q;
`else
    assign load_val = bus.bin;
    assign bus.neg  = 1'b0;
`endif

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
`ifdef BCD_SEQ_SIGNED_EN
        sign_d   = sign_q;
        neg_d    = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    shreg_d  = load_val;
                    digits_d = '0;
                    cnt_d    = CNT_W'(BIN_W);
`ifdef BCD_SEQ_SIGNED_EN
                    sign_d   = bus.bin[BIN_W-1];
`endif
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                digits_d = step_digits;
                shreg_d  = step_shreg;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = step_digits;
`ifdef BCD_SEQ_SIGNED_EN
                    neg_d   = sign_q;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d == SHIFT);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            digits_q    <= '0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef BCD_SEQ_SIGNED_EN
            sign_q      <= 1'b0;
            neg_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            digits_q    <= digits_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef BCD_SEQ_SIGNED_EN
            sign_q      <= sign_d;
            neg_q       <= neg_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.bcd       = bcd_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Directed bench for bcd_seq_ctrl: an 8-bit/3-digit instance and a 12-bit/4-digit instance.
module tb_bcd_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy_a, busy_b;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    always #5 clk = ~clk;

    bcd_seq_ctrl_if #(.BIN_W(8),  .DIGITS(3)) ifa ();
    bcd_seq_ctrl_if #(.BIN_W(12), .DIGITS(4)) ifb ();

    bcd_seq_ctrl #(.BIN_W(8), .DIGITS(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave),
        .busy  (busy_a)
    );

    bcd_seq_ctrl #(.BIN_W(12), .DIGITS(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave),
        .busy  (busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept v on the 8-bit instance, track latency, check the result, then drain it.
    task automatic run_a(input string tag, input logic [7:0] v,
                         input logic [11:0] exp_bcd, input logic exp_neg);
        int n;
        check({tag, "_in_ready"}, 32'(ifa.in_ready), 32'd1);
        ifa.bin      = v;
        ifa.in_valid = 1'b1;
        tick();
        ifa.in_valid = 1'b0;
        check({tag, "_busy"}, 32'(busy_a), 32'd1);
        n = 0;
        while (!ifa.out_valid && n < 20) begin
            check({tag, "_rdy_low"}, 32'(ifa.in_ready), 32'd0);
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd8);
        check({tag, "_bcd"}, 32'(ifa.bcd), 32'(exp_bcd));
        check({tag, "_neg"}, 32'(ifa.neg), 32'(exp_neg));
        ifa.out_ready = 1'b1;
        tick();
        ifa.out_ready = 1'b0;
        check({tag, "_ov_drop"}, 32'(ifa.out_valid), 32'd0);
        check({tag, "_idle"}, 32'(ifa.in_ready), 32'd1);
    endtask

    initial begin
        int n;
        ifa.in_valid = 1'b0; ifa.bin = '0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.bin = '0; ifb.out_ready = 1'b0;
        #12;
        check("rst_ov",   32'(ifa.out_valid), 32'd0);
        check("rst_bcd",  32'(ifa.bcd),       32'd0);
        check("rst_busy", 32'(busy_a),        32'd0);
        check("rst_neg",  32'(ifa.neg),       32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_rdy", 32'(ifa.in_ready), 32'd1);

`ifdef BCD_SEQ_SIGNED_EN
        run_a("s80", 8'h80, 12'h128, 1'b1);
        run_a("sff", 8'hFF, 12'h001, 1'b1);
        run_a("s7f", 8'h7F, 12'h127, 1'b0);
        run_a("s00", 8'd0,  12'h000, 1'b0);
`else
        run_a("u255", 8'd255, 12'h255, 1'b0);
        run_a("u0",   8'd0,   12'h000, 1'b0);
        run_a("u99",  8'd99,  12'h099, 1'b0);
`endif

        // Back-pressure on 128 (0x80) while a competing in_valid is offered.
        ifa.bin = 8'd128; ifa.in_valid = 1'b1;
        tick();
        ifa.bin = 8'd55;
        n = 0;
        while (!ifa.out_valid && n < 20) begin tick(); n++; end
        check("bp_latency", 32'(n), 32'd8);
        for (int i = 0; i < 5; i++) begin
            check("bp_ov",  32'(ifa.out_valid), 32'd1);
            check("bp_bcd", 32'(ifa.bcd),       32'h128);
            check("bp_rdy", 32'(ifa.in_ready),  32'd0);
            tick();
        end
`ifdef BCD_SEQ_SIGNED_EN
        check("bp_neg", 32'(ifa.neg), 32'd1);
`else
        check("bp_neg", 32'(ifa.neg), 32'd0);
`endif
        ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
        tick();
        ifa.out_ready = 1'b0;
        check("bp_drop", 32'(ifa.out_valid), 32'd0);
        tick();
        check("bp_no_queue", 32'(busy_a), 32'd0);
        check("bp_bcd_hold", 32'(ifa.bcd), 32'h128);

        // Reset in the middle of a conversion of 200.
        ifa.bin = 8'd200; ifa.in_valid = 1'b1;
        tick();
        ifa.in_valid = 1'b0;
        repeat (4) tick();
        check("mid_busy_pre", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_ov",   32'(ifa.out_valid), 32'd0);
        check("mid_busy", 32'(busy_a),        32'd0);
        check("mid_bcd",  32'(ifa.bcd),       32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        run_a("post_rst7", 8'd7, 12'h007, 1'b0);

        // Wide instance: 4095 over 12 iterations.
        check("b_rdy", 32'(ifb.in_ready), 32'd1);
        ifb.bin = 12'd4095; ifb.in_valid = 1'b1;
        tick();
        ifb.in_valid = 1'b0;
        n = 0;
        while (!ifb.out_valid && n < 30) begin tick(); n++; end
        check("b_latency", 32'(n), 32'd12);
`ifdef BCD_SEQ_SIGNED_EN
        check("b_bcd", 32'(ifb.bcd), 32'h0001);
        check("b_neg", 32'(ifb.neg), 32'd1);
`else
        check("b_bcd", 32'(ifb.bcd), 32'h4095);
        check("b_neg", 32'(ifb.neg), 32'd0);
`endif
        ifb.out_ready = 1'b1;
        tick();
        ifb.out_ready = 1'b0;
        check("b_drop", 32'(ifb.out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
